corefifo_wr_ptr_ctrl: RTL and testbench
=======================================

# corefifo_wr_ptr_ctrl

Write-side pointer and status generator for the asynchronous FIFO. It sits in the write clock domain. It consumes the read pointer after that pointer has been synchronized and converted from Gray to binary. It produces the memory write address and write enable, the Gray-coded write pointer that is sent to the read domain, and the full, almost-full, count and overflow status.

## Interface
Parameters:
- ADDRWIDTH, 3: memory address width. Depth is 2^ADDRWIDTH. Pointers are ADDRWIDTH+1 bits.
- AFULL_VAL, 6: almost-full threshold in words, 1..2^ADDRWIDTH. Used only when COREFIFO_AFULL_EN is defined.

Ports:
- clk  in  1  write clock. All state is updated on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- rd_ptr_bin  in  ADDRWIDTH+1  read pointer, already synchronized into the clk domain and converted to binary.
- mem_we  out  1  memory write enable. Combinational: wr_en & ~full.
- wr_addr  out  ADDRWIDTH  memory write address, equal to wr_ptr_bin[ADDRWIDTH-1:0].
- wr_ptr_gray  out  ADDRWIDTH+1  registered Gray-coded write pointer, sent to the read-domain synchronizer.
- full  out  1  registered full flag.
- afull  out  1  registered almost-full flag.
- wr_cnt  out  ADDRWIDTH+1  registered occupancy as seen from the write side.
- overflow  out  1  registered one-cycle pulse: a write was rejected.

## Operation
- Push accepted: push = wr_en & ~full.
- wr_ptr_bin:
  - Internal ADDRWIDTH+1-bit register.
  - wr_ptr_next = wr_ptr_bin + push, modulo 2^(ADDRWIDTH+1).
  - Wraps from all-ones to 0.
- wr_ptr_gray:
  - Registered from wr_ptr_next ^ (wr_ptr_next >> 1).
  - No combinational path to the output, so the pointer is glitch-free for crossing domains.
  - Exactly one bit changes per accepted push.
- Occupancy: diff = (wr_ptr_next − rd_ptr_bin) modulo 2^(ADDRWIDTH+1).
  - wr_cnt <= diff
  - full <= (diff == 2^ADDRWIDTH)
  - afull <= (diff >= AFULL_VAL)
- overflow <= wr_en & full. The pointer and count are unchanged on a rejected write.
- rd_ptr_bin must never lead wr_ptr_bin and must never trail it by more than 2^ADDRWIDTH. The block does not check this. Outputs are defined only modulo under these conditions.
- No state machine. The block is a pointer counter plus registered status computed from the next-state pointer.

## Timing
- Reset values (asynchronous, applied immediately): wr_ptr_bin=0, wr_ptr_gray=0, full=0, afull=0, wr_cnt=0, overflow=0.
  - mem_we=0 while full=0 and wr_en=0.
  - wr_addr=0.
- Write accepted at edge N:
  - wr_addr advances, wr_ptr_gray updates, and wr_cnt/full/afull reflect the new word, all at edge N.
  - Latency is 0 cycles after the edge.
- The write that fills the FIFO asserts full at that same edge. A wr_en in the next cycle is rejected.
- A rd_ptr_bin change between edges is reflected in full/afull/wr_cnt at the next edge (1-cycle latency).
- Write and read pointer advancing in the same cycle: diff uses both new values, so wr_cnt is unchanged. full is not asserted if the read freed a slot.
- Reset asserted mid-operation: all outputs return to reset values without waiting for a clock edge. The read domain must be reset at the same time.
- Reset release: the first edge after deassertion may accept a write.

## Configuration
- COREFIFO_AFULL_EN:
  - Defined: afull is computed against AFULL_VAL as described above.
  - Undefined: afull is tied to 0, no compare logic is generated, and AFULL_VAL is ignored.

## Structure
- Shared package corefifo_pkg holds:
  - function bin2gray(ADDRWIDTH+1 bits)
  - constant COREFIFO_PTR_EXTRA = 1, the wrap bit added to the address width
- One sub-module: corefifo_binToGrayConv, combinational, parameter ADDRWIDTH. It is the inverse of the read-domain Gray-to-binary converter and is instantiated on wr_ptr_next.
- The status compare stays inline. No further hierarchy.

## Test plan
All scenarios use ADDRWIDTH=3, AFULL_VAL=6, with COREFIFO_AFULL_EN defined unless stated otherwise.
1. Assert reset mid-stream at wr_cnt=5 → all outputs go to 0 without waiting for an edge, and wr_addr=0.
2. Hold rd_ptr_bin=0 and give 8 consecutive wr_en cycles:
   - wr_ptr_gray sequence: 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
   - wr_cnt goes 1..8.
   - afull=1 from the 6th write.
   - full=1 at the 8th edge.
3. FIFO full and wr_en held for 2 cycles → mem_we=0, overflow=1 for exactly those 2 cycles, pointer stays 8, wr_cnt stays 8.
4. FIFO full, then set rd_ptr_bin=3 → next edge: full=0, wr_cnt=5, afull=0. A following write gives wr_cnt=6 and afull=1.
5. Wrap-around: wr_ptr_bin=15, rd_ptr_bin=12, one write → wr_ptr_gray=0000, wr_addr=0, wr_cnt=4, full=0.
6. Run scenario 2 with COREFIFO_AFULL_EN undefined → afull stays 0 throughout. All other outputs are identical to the defined case.

Source files
------------

// File: rtl/corefifo_pkg.sv
// corefifo_pkg -- shared definitions for the async FIFO pointer logic.
//   COREFIFO_PTR_EXTRA : wrap bit added on top of the memory address width.
//   bin2gray()         : binary to reflected Gray code. Width-agnostic: callers
//                        zero-extend into PTR_MAX_W bits and truncate the result.
package corefifo_pkg;

  localparam int COREFIFO_PTR_EXTRA = 1;
  localparam int PTR_MAX_W          = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/corefifo_wr_ptr_ctrl_if.sv
// corefifo_wr_ptr_ctrl_if -- write-side FIFO control bus.
//   master : write client / FIFO top (drives wr_en and the synchronized rd_ptr_bin)
//   slave  : corefifo_wr_ptr_ctrl (drives memory write strobe/address, Gray
//            pointer and write-side status)
interface corefifo_wr_ptr_ctrl_if
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH = 3
);
  localparam int PW = ADDRWIDTH + COREFIFO_PTR_EXTRA;

  logic                 wr_en;
  logic [PW-1:0]        rd_ptr_bin;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [PW-1:0]        wr_ptr_gray;
  logic                 full;
  logic                 afull;
  logic [PW-1:0]        wr_cnt;
  logic                 overflow;

  modport master (
    output wr_en, rd_ptr_bin,
    input  mem_we, wr_addr, wr_ptr_gray, full, afull, wr_cnt, overflow
  );

  modport slave (
    input  wr_en, rd_ptr_bin,
    output mem_we, wr_addr, wr_ptr_gray, full, afull, wr_cnt, overflow
  );
endinterface

// File: rtl/corefifo_binToGrayConv.sv
// corefifo_binToGrayConv -- combinational binary to Gray converter for an
// ADDRWIDTH+1 bit FIFO pointer. Inverse of the read-side Gray to binary stage.
//   bin  : binary pointer in
//   gray : Gray-coded pointer out
module corefifo_binToGrayConv
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH = 3
) (
  input  logic [ADDRWIDTH+COREFIFO_PTR_EXTRA-1:0] bin,
  output logic [ADDRWIDTH+COREFIFO_PTR_EXTRA-1:0] gray
);
  localparam int PW = ADDRWIDTH + COREFIFO_PTR_EXTRA;

  assign gray = PW'(bin2gray(PTR_MAX_W'(bin)));
endmodule

// File: rtl/corefifo_wr_ptr_ctrl.sv
// corefifo_wr_ptr_ctrl -- write-domain pointer and status generator.
//   clk   : write clock
//   reset : asynchronous, active-high
//   wif   : slave side of corefifo_wr_ptr_ctrl_if
//           in  wr_en, rd_ptr_bin (already synchronized, binary)
//           out mem_we, wr_addr, wr_ptr_gray, full, afull, wr_cnt, overflow
// Build option: COREFIFO_AFULL_EN enables the almost-full compare against
// AFULL_VAL; without it afull is constant 0.
// All status is registered from the next-state pointer so it reflects a write
// at the same edge that accepts it.
module corefifo_wr_ptr_ctrl
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH = 3,
  parameter int AFULL_VAL = 6
) (
  input logic                   clk,
  input logic                   reset,
  corefifo_wr_ptr_ctrl_if.slave wif
);
  localparam int PW = ADDRWIDTH + COREFIFO_PTR_EXTRA;

  logic [PW-1:0] wr_ptr_bin;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] diff;
  logic          push;

  assign push        = wif.wr_en & ~wif.full;
  assign wr_ptr_next = wr_ptr_bin + PW'(push);
  // Modulo arithmetic; valid while the read pointer never leads and trails
  // by at most the FIFO depth.
  assign diff        = wr_ptr_next - wif.rd_ptr_bin;

  assign wif.mem_we  = push;
  assign wif.wr_addr = wr_ptr_bin[ADDRWIDTH-1:0];

  corefifo_binToGrayConv #(.ADDRWIDTH(ADDRWIDTH)) u_b2g (
    .bin  (wr_ptr_next),
    .gray (gray_next)
  );

  // Gray pointer is taken straight from a flop so the crossing sees one
  // clean bit change per push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_bin      <= '0;
      wif.wr_ptr_gray <= '0;
      wif.full        <= 1'b0;
      wif.wr_cnt      <= '0;
      wif.overflow    <= 1'b0;
    end else begin
      wr_ptr_bin      <= wr_ptr_next;
      wif.wr_ptr_gray <= gray_next;
      wif.full        <= (diff == PW'(1 << ADDRWIDTH));
      wif.wr_cnt      <= diff;
      wif.overflow    <= wif.wr_en & wif.full;
    end
  end

`ifdef COREFIFO_AFULL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wif.afull <= 1'b0;
    else       wif.afull <= (diff >= PW'(AFULL_VAL));
  end
`else
  assign wif.afull = 1'b0;
`endif

endmodule

// File: tb/tb_corefifo_wr_ptr_ctrl.sv
module tb_corefifo_wr_ptr_ctrl;
  logic clk;
  logic reset;

  corefifo_wr_ptr_ctrl_if #(.ADDRWIDTH(3)) wif ();

  corefifo_wr_ptr_ctrl #(.ADDRWIDTH(3), .AFULL_VAL(6)) dut (
    .clk   (clk),
    .reset (reset),
    .wif   (wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: total words ever written / read as plain integers,
  // plus the registered status as seen after the last edge.
  int m_wp, m_rp, m_cnt;
  bit m_full, m_ovf, exp_we, seen_we;

  function automatic bit m_afull(int cnt);
`ifdef COREFIFO_AFULL_EN
    return cnt >= 6;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_gray(int w);
    int p;
    p = w % 16;
    return 4'(p ^ (p >> 1));
  endfunction

  task automatic model_reset();
    m_wp = 0; m_rp = 0; m_cnt = 0; m_full = 0; m_ovf = 0;
  endtask

  // Drives one cycle (inputs set just after an edge), records mem_we before
  // the next edge, advances the model, and returns 1 ns after that edge.
  task automatic drive_cycle(input bit we, input int rp);
    wif.wr_en      = we;
    wif.rd_ptr_bin = 4'(rp % 16);
    #1;
    seen_we = wif.mem_we;
    exp_we  = we & ~m_full;
    m_ovf   = we & m_full;
    if (exp_we) m_wp++;
    m_rp   = rp;
    m_cnt  = m_wp - m_rp;
    m_full = (m_cnt == 8);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; wif.wr_en = 1'b0; wif.rd_ptr_bin = '0;
    model_reset();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (wif.wr_ptr_gray !== 4'd0 || wif.full !== 1'b0 || wif.afull !== 1'b0 ||
                 wif.wr_cnt !== 4'd0 || wif.overflow !== 1'b0 || wif.mem_we !== 1'b0 ||
                 wif.wr_addr !== 3'd0) begin
      n_fail++; $display("FAIL reset_init gray=%b full=%b afull=%b cnt=%0d ovf=%b we=%b addr=%0d expected all 0",
                         wif.wr_ptr_gray, wif.full, wif.afull, wif.wr_cnt, wif.overflow, wif.mem_we, wif.wr_addr);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 0);
    wif.wr_en = 1'b0;
    n_chk++; if (wif.wr_cnt !== 4'd5) begin
      n_fail++; $display("FAIL reset_prefill wr_cnt=%0d expected 5", wif.wr_cnt);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (wif.wr_ptr_gray !== 4'd0 || wif.full !== 1'b0 || wif.afull !== 1'b0 ||
                 wif.wr_cnt !== 4'd0 || wif.overflow !== 1'b0 || wif.mem_we !== 1'b0 ||
                 wif.wr_addr !== 3'd0) begin
      n_fail++; $display("FAIL reset_async gray=%b full=%b afull=%b cnt=%0d ovf=%b we=%b addr=%0d expected all 0",
                         wif.wr_ptr_gray, wif.full, wif.afull, wif.wr_cnt, wif.overflow, wif.mem_we, wif.wr_addr);
    end
    apply_reset();
  endtask

  task automatic test_fill();
    logic [3:0] gseq [8];
    gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 0);
      n_chk++; if (seen_we !== 1'b1) begin
        n_fail++; $display("FAIL fill_mem_we[%0d] got=%b expected 1", i, seen_we);
      end
      n_chk++; if (wif.wr_ptr_gray !== gseq[i]) begin
        n_fail++; $display("FAIL fill_gray[%0d] got=%b expected %b", i, wif.wr_ptr_gray, gseq[i]);
      end
      n_chk++; if (wif.wr_cnt !== 4'(i + 1)) begin
        n_fail++; $display("FAIL fill_cnt[%0d] got=%0d expected %0d", i, wif.wr_cnt, i + 1);
      end
      n_chk++; if (wif.afull !== m_afull(i + 1)) begin
        n_fail++; $display("FAIL fill_afull[%0d] got=%b expected %b", i, wif.afull, m_afull(i + 1));
      end
      n_chk++; if (wif.full !== (i == 7)) begin
        n_fail++; $display("FAIL fill_full[%0d] got=%b expected %b", i, wif.full, (i == 7));
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 0);
      n_chk++; if (seen_we !== 1'b0) begin
        n_fail++; $display("FAIL ovf_mem_we[%0d] got=%b expected 0", i, seen_we);
      end
      n_chk++; if (wif.overflow !== 1'b1) begin
        n_fail++; $display("FAIL ovf_pulse[%0d] got=%b expected 1", i, wif.overflow);
      end
      n_chk++; if (wif.wr_cnt !== 4'd8 || wif.wr_addr !== 3'd0 || wif.wr_ptr_gray !== 4'b1100 || wif.full !== 1'b1) begin
        n_fail++; $display("FAIL ovf_hold[%0d] cnt=%0d addr=%0d gray=%b full=%b expected 8/0/1100/1",
                           i, wif.wr_cnt, wif.wr_addr, wif.wr_ptr_gray, wif.full);
      end
    end
    drive_cycle(1'b0, 0);
    n_chk++; if (wif.overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_end got=%b expected 0", wif.overflow);
    end
  endtask

  task automatic test_read_release();
    drive_cycle(1'b0, 3);
    n_chk++; if (wif.full !== 1'b0 || wif.wr_cnt !== 4'd5 || wif.afull !== 1'b0) begin
      n_fail++; $display("FAIL rel_read full=%b cnt=%0d afull=%b expected 0/5/0", wif.full, wif.wr_cnt, wif.afull);
    end
    drive_cycle(1'b1, 3);
    n_chk++; if (seen_we !== 1'b1 || wif.wr_cnt !== 4'd6 || wif.afull !== m_afull(6)) begin
      n_fail++; $display("FAIL rel_write we=%b cnt=%0d afull=%b expected 1/6/%b", seen_we, wif.wr_cnt, wif.afull, m_afull(6));
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 15; i++) drive_cycle(1'b1, (m_wp > 3) ? m_wp - 3 : 0);
    n_chk++; if (wif.wr_ptr_gray !== 4'b1000 || wif.wr_addr !== 3'd7) begin
      n_fail++; $display("FAIL wrap_pre gray=%b addr=%0d expected 1000/7", wif.wr_ptr_gray, wif.wr_addr);
    end
    drive_cycle(1'b1, 12);
    n_chk++; if (wif.wr_ptr_gray !== 4'b0000 || wif.wr_addr !== 3'd0 || wif.wr_cnt !== 4'd4 || wif.full !== 1'b0) begin
      n_fail++; $display("FAIL wrap gray=%b addr=%0d cnt=%0d full=%b expected 0000/0/4/0",
                         wif.wr_ptr_gray, wif.wr_addr, wif.wr_cnt, wif.full);
    end
  endtask

  task automatic test_random();
    bit we;
    int rp;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      we = ($urandom % 4) != 0;
      rp = m_rp;
      if (($urandom % 3) == 0) rp = m_rp + $urandom_range(0, m_wp - m_rp);
      drive_cycle(we, rp);
      n_chk++; if (seen_we !== exp_we || wif.overflow !== m_ovf || wif.full !== m_full ||
                   wif.wr_cnt !== 4'(m_cnt) || wif.afull !== m_afull(m_cnt) ||
                   wif.wr_ptr_gray !== m_gray(m_wp) || wif.wr_addr !== 3'(m_wp % 8)) begin
        n_fail++; $display("FAIL rand[%0d] we=%b/%b ovf=%b/%b full=%b/%b cnt=%0d/%0d afull=%b/%b gray=%b/%b addr=%0d/%0d (got/expected)",
                           i, seen_we, exp_we, wif.overflow, m_ovf, wif.full, m_full, wif.wr_cnt, m_cnt,
                           wif.afull, m_afull(m_cnt), wif.wr_ptr_gray, m_gray(m_wp), wif.wr_addr, m_wp % 8);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    wif.wr_en = 1'b0;
    wif.rd_ptr_bin = '0;
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_read_release();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
